ps2_keyboard_rx: RTL and testbench
==================================

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, scancode buffer entries (power of two).
REQ-002 Parameter: TIMEOUT_CYCLES, 10000, clk cycles without a PS/2 falling edge before a partial frame is abandoned (100 us at 100 MHz).
REQ-003 Port: clk  input  1  system clock; the only clock in the block.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 Port: ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 Port: rd  input  1  CPU pop strobe, one cycle per byte.
REQ-008 Port: clr_err  input  1  clears the sticky overflow and frame_err flags.
REQ-009 Port: scancode  output  8  FIFO head byte; 8'h00 when empty.
REQ-010 Port: keyboard_intr  output  1  interrupt to the CPU; high while the FIFO is non-empty.
REQ-011 Port: fifo_count  output  3  occupancy, 0..FIFO_DEPTH.
REQ-012 Port: overflow  output  1  sticky; a valid byte was dropped because the FIFO was full.
REQ-013 Port: frame_err  output  1  sticky; a frame failed the start, parity or stop check.

Function
REQ-014 ps2_clk and ps2_data each SHALL pass through a 2-flop synchronizer; a falling edge SHALL be detected from a third registered copy of ps2_clk, giving a one-cycle strobe fe.
REQ-015 The FSM SHALL have the states IDLE, DATA, PARITY and STOP; every transition SHALL occur only on fe, except for timeout.
REQ-016 IDLE: on fe with data=0 (start bit), go to DATA and clear the bit counter; on fe with data=1, stay in IDLE and leave frame_err unchanged.
REQ-017 DATA: on each fe, shift data in LSB first; after the 8th bit, go to PARITY.
REQ-018 PARITY: on fe, capture the bit and go to STOP.
REQ-019 STOP: on fe, the frame is valid if stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity); always return to IDLE.
REQ-020 Valid frame: the byte SHALL be pushed on the clk cycle after the STOP fe; if the FIFO is full, the byte is dropped and overflow is set.
REQ-021 Invalid frame: no push; frame_err is set.
REQ-022 Timeout: in any state other than IDLE, a cycle counter SHALL count clk cycles since the last fe; on reaching TIMEOUT_CYCLES, return to IDLE, set no flag and push nothing.
REQ-023 FIFO: circular, with read and write pointers that wrap modulo FIFO_DEPTH; fifo_count SHALL be one bit wider than the pointers so that full is distinguishable from empty.
REQ-024 Pop: rd pops the head when the FIFO is non-empty; rd when empty SHALL be ignored, with no pointer change.
REQ-025 Simultaneous push and pop in one cycle:
  - both take effect;
  - fifo_count is unchanged;
  - when full, the pop frees the slot, so the push succeeds and overflow is not set.
REQ-026 scancode SHALL update combinationally from the head pointer, so the new head is visible the cycle after a pop.
REQ-027 keyboard_intr SHALL be registered and equal (fifo_count != 0), lagging fifo_count by one cycle.
REQ-028 Latency: keyboard_intr SHALL assert no later than 6 clk cycles after the raw ps2_clk falls on the stop bit.
REQ-029 clr_err SHALL clear both sticky flags; if a set event occurs in the same cycle, the set wins.

Reset
REQ-030 Asserting rst SHALL immediately bring:
  - the FSM to IDLE;
  - the pointers, fifo_count, bit counter and timeout counter to 0;
  - scancode to 8'h00, keyboard_intr to 0, overflow to 0, frame_err to 0;
  - the synchronizer flops to 1 (the idle bus level).
REQ-031 Asserting rst mid-frame SHALL discard the partial frame; the next start bit after rst deasserts SHALL be received normally.

Verification (PS/2 bit period 40 us; bits listed start, D0..D7, parity, stop)
REQ-032 Single frame 0x1C (0,0,0,1,1,1,0,0,0,0,1) -> scancode=8'h1C, fifo_count=1, keyboard_intr=1; one rd -> fifo_count=0, keyboard_intr=0 one cycle later, scancode=8'h00.
REQ-033 Frames 0xF0, 0x1C back to back -> fifo_count=2; pops return 8'hF0, then 8'h1C; flags remain 0.
REQ-034 Five valid frames 0x01..0x05 with no rd -> fifo_count=4, overflow=1; pops return 0x01..0x04; clr_err -> overflow=0.
REQ-035 Frame 0x1C with the parity bit set to 1 -> fifo_count unchanged, frame_err=1; a following valid 0x5A (parity 1) is received as 8'h5A.
REQ-036 Start plus 4 data bits, then idle for 10000 cycles, then a valid 0x5A -> exactly one byte 8'h5A is received and frame_err=0.
REQ-037 Full FIFO, with rd asserted in the cycle of the push of 0x06 -> fifo_count stays 4, overflow=0, and the last pop yields 8'h06.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard frame receiver with a scancode FIFO and interrupt.
module ps2_keyboard_rx #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd,
  input  logic                          clr_err,
  output logic [7:0]                    scancode,
  output logic                          keyboard_intr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t r_state, w_next;
  logic [1:0] r_clk_s, r_data_s;
  logic r_clk_d, w_fe, w_d;
  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic r_par, r_push, w_ok, w_bad, w_tmo, w_pop, w_wr;
  logic [TW-1:0] r_tmo;
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_clk_s  <= 2'b11;
      r_data_s <= 2'b11;
      r_clk_d  <= 1'b1;
    end else begin
      r_clk_s  <= {r_clk_s[0], ps2_clk};
      r_data_s <= {r_data_s[0], ps2_data};
      r_clk_d  <= r_clk_s[1];
    end
  assign w_fe  = r_clk_d & ~r_clk_s[1];
  assign w_d   = r_data_s[1];
  assign w_tmo = r_state != IDLE && !w_fe && r_tmo == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_tmo) w_next = IDLE;
    else if (w_fe)
      case (r_state)
        IDLE:    w_next = w_d ? IDLE : DATA;
        DATA:    w_next = (r_bit == 3'd7) ? PARITY : DATA;
        PARITY:  w_next = STOP;
        default: w_next = IDLE;
      endcase
  end
  // odd parity: data bits and parity bit together must hold an odd number of ones
  always_comb begin
    w_ok  = w_fe && r_state == STOP && w_d && (^{r_shift, r_par});
    w_bad = w_fe && r_state == STOP && !w_ok;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_shift <= '0;
      r_bit   <= '0;
      r_par   <= 1'b0;
      r_tmo   <= '0;
      r_push  <= 1'b0;
    end else begin
      r_tmo  <= (r_state == IDLE || w_fe) ? '0 : r_tmo + 1'b1;
      r_push <= w_ok;
      if (w_fe && r_state == IDLE) r_bit <= '0;
      if (w_fe && r_state == DATA) begin
        r_shift <= {w_d, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
      if (w_fe && r_state == PARITY) r_par <= w_d;
    end
  // a pop in the push cycle frees the slot, so a full FIFO still accepts the byte
  assign w_pop = rd && fifo_count != '0;
  assign w_wr  = r_push && (fifo_count != (PW+1)'(FIFO_DEPTH) || w_pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      fifo_count    <= '0;
      keyboard_intr <= 1'b0;
      overflow      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      fifo_count    <= fifo_count + (PW+1)'(w_wr) - (PW+1)'(w_pop);
      keyboard_intr <= fifo_count != '0;
      overflow      <= (r_push && !w_wr) || (overflow && !clr_err);
      frame_err     <= w_bad || (frame_err && !clr_err);
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr] <= r_shift;
  assign scancode = (fifo_count != '0) ? r_mem[r_rptr] : 8'h00;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: directed PS/2 frames checked against a queue-based FIFO model.
module tb_ps2_keyboard_rx;
  localparam int HB = 20;
  logic clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1, rd = 0, clr_err = 0;
  logic [7:0] scancode;
  logic keyboard_intr, overflow, frame_err;
  logic [2:0] fifo_count;
  int checks = 0, errs = 0;
  bit chk_en = 0;
  logic [7:0] q[$];
  bit m_ovf = 0, m_ferr = 0;
  ps2_keyboard_rx dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd(rd),
    .clr_err(clr_err), .scancode(scancode), .keyboard_intr(keyboard_intr),
    .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (chk_en) begin
      chk("model_scancode", scancode, q.size() != 0 ? q[0] : 8'h00);
      chk("model_count", fifo_count, q.size());
      chk("model_intr", keyboard_intr, q.size() != 0);
      chk("model_overflow", overflow, m_ovf);
      chk("model_frame_err", frame_err, m_ferr);
    end
  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (HB) @(negedge clk);
    ps2_clk = 0;
    repeat (HB) @(negedge clk);
    ps2_clk = 1;
  endtask
  task automatic send(input logic [7:0] b, input logic par, input logic stp,
                      input bit pop_at_push, output logic [7:0] popped);
    logic [10:0] f;
    bit valid;
    f = {stp, par, b, 1'b0};
    valid = stp && (^{b, par});
    popped = 8'h00;
    chk_en = 0;
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    @(negedge clk) ps2_data = f[10];
    repeat (HB) @(negedge clk);
    ps2_clk = 0;
    if (pop_at_push) begin
      repeat (3) @(posedge clk);
      #1 popped = scancode;
      rd = 1;
      @(posedge clk);
      #1 rd = 0;
    end else if (valid && q.size() == 0) begin
      repeat (6) @(posedge clk);
      #1 chk("intr_latency", keyboard_intr, 1);
    end
    repeat (HB) @(negedge clk);
    ps2_clk = 1;
    repeat (8) @(negedge clk);
    if (pop_at_push && q.size() != 0) void'(q.pop_front());
    if (!valid) m_ferr = 1;
    else if (q.size() < 4) q.push_back(b);
    else m_ovf = 1;
    chk_en = 1;
  endtask
  task automatic frame(input logic [7:0] b);
    logic [7:0] d;
    send(b, ~^b, 1'b1, 0, d);
  endtask
  task automatic partial(input logic [7:0] b, input int n);
    logic [8:0] f;
    f = {b, 1'b0};
    chk_en = 0;
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
  endtask
  task automatic pop(output logic [7:0] v);
    chk_en = 0;
    @(negedge clk) v = scancode;
    rd = 1;
    @(negedge clk) rd = 0;
    @(negedge clk);
    if (q.size() != 0) void'(q.pop_front());
    chk_en = 1;
  endtask
  task automatic clear();
    chk_en = 0;
    @(negedge clk) clr_err = 1;
    @(negedge clk) clr_err = 0;
    m_ovf = 0;
    m_ferr = 0;
    chk_en = 1;
  endtask
  task automatic do_reset();
    chk_en = 0;
    @(negedge clk) rst = 1;
    #1;
    chk("rst_count", fifo_count, 0);
    chk("rst_code", scancode, 8'h00);
    chk("rst_intr", keyboard_intr, 0);
    chk("rst_flags", {overflow, frame_err}, 2'b00);
    ps2_clk = 1;
    ps2_data = 1;
    q.delete();
    m_ovf = 0;
    m_ferr = 0;
    @(negedge clk) rst = 0;
    chk_en = 1;
  endtask
  initial begin
    logic [7:0] v;
    repeat (3) @(negedge clk);
    chk("init_count", fifo_count, 0);
    chk("init_code", scancode, 8'h00);
    chk("init_flags", {keyboard_intr, overflow, frame_err}, 3'b000);
    rst = 0;
    chk_en = 1;
    // single frame, then pop with intr lagging count by one cycle
    frame(8'h1C);
    chk("one_code", scancode, 8'h1C);
    chk("one_count", fifo_count, 1);
    chk("one_intr", keyboard_intr, 1);
    chk_en = 0;
    @(negedge clk) rd = 1;
    @(negedge clk) rd = 0;
    chk("pop_count", fifo_count, 0);
    chk("pop_code", scancode, 8'h00);
    chk("pop_intr_lag", keyboard_intr, 1);
    @(negedge clk);
    chk("pop_intr", keyboard_intr, 0);
    void'(q.pop_front());
    chk_en = 1;
    // back to back
    frame(8'hF0);
    frame(8'h1C);
    chk("b2b_count", fifo_count, 2);
    pop(v); chk("b2b_pop0", v, 8'hF0);
    pop(v); chk("b2b_pop1", v, 8'h1C);
    chk("b2b_flags", {overflow, frame_err}, 2'b00);
    // overflow
    for (int i = 1; i <= 5; i++) frame(8'(i));
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      pop(v); chk("ovf_pop", v, i);
    end
    clear();
    chk("ovf_clr", overflow, 0);
    // bad parity, then valid frame
    send(8'h1C, 1'b1, 1'b1, 0, v);
    chk("par_count", fifo_count, 0);
    chk("par_err", frame_err, 1);
    frame(8'h5A);
    pop(v); chk("par_next", v, 8'h5A);
    clear();
    // bad stop bit
    send(8'h33, 1'b1, 1'b0, 0, v);
    chk("stop_err", frame_err, 1);
    chk("stop_count", fifo_count, 0);
    clear();
    // timeout abandons a partial frame silently
    partial(8'h0F, 5);
    repeat (10050) @(negedge clk);
    chk_en = 1;
    frame(8'h5A);
    chk("tmo_count", fifo_count, 1);
    chk("tmo_err", frame_err, 0);
    pop(v); chk("tmo_pop", v, 8'h5A);
    // reset mid-frame
    partial(8'hAA, 6);
    do_reset();
    frame(8'h1C);
    pop(v); chk("rst_mid_pop", v, 8'h1C);
    // full FIFO with pop in the push cycle
    do_reset();
    for (int i = 1; i <= 4; i++) frame(8'(i));
    send(8'h06, ~^8'h06, 1'b1, 1, v);
    chk("pp_popped", v, 8'h01);
    chk("pp_count", fifo_count, 4);
    chk("pp_ovf", overflow, 0);
    pop(v); chk("pp_pop0", v, 8'h02);
    pop(v); chk("pp_pop1", v, 8'h03);
    pop(v); chk("pp_pop2", v, 8'h04);
    pop(v); chk("pp_pop3", v, 8'h06);
    chk_en = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end
endmodule
